// File: rtl/basic_func_pwm_pkg.sv
// Shared definitions for the basic_func_pwm_array LED driver: register map, CTRL/PRESC
// field positions and the byte-lane mask helper.
package basic_func_pwm_pkg;

  localparam int unsigned REG_CTRL  = 0;
  localparam int unsigned REG_PRESC = 1;
  localparam int unsigned REG_DUTY0 = 2;

  localparam int unsigned CTRL_RUN_BIT  = 0;
  localparam int unsigned CTRL_POL_BIT  = 1;
  localparam int unsigned CTRL_STEN_BIT = 31;

  localparam int unsigned PRESC_LSB  = 0;
  localparam int unsigned FADE_LSB   = 16;
  localparam int unsigned FADE_DIV_W = 16;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pwm_led_chan.sv
// One PWM LED channel: target/active duty shadow, optional fade stepper (PWM_FADE_EN),
// duty compare and registered pin driver.
module pwm_led_chan
  import basic_func_pwm_pkg::*;
#(
  parameter int PWM_W      = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_pol,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_fade_imm,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic             i_tgt_we,
  input  logic [PWM_W-1:0] i_tgt_wdata,
  output logic [PWM_W-1:0] o_target,
  output logic             o_led
);

  localparam logic P_AL = (ACTIVE_LOW != 0);

  logic [PWM_W-1:0] r_target;
  logic [PWM_W-1:0] r_active;
  logic [PWM_W-1:0] w_active_nxt;
  logic             r_led;
  logic             w_on;

  // Target register, written by the bus or the stream at any time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_target <= {PWM_W{1'b0}};
    end else if (i_tgt_we) begin
      r_target <= i_tgt_wdata;
    end
  end

`ifdef PWM_FADE_EN
  always_comb begin
    w_active_nxt = r_active;
    if (i_load) begin
      if (i_fade_imm) begin
        w_active_nxt = r_target;
      end else if (!i_step) begin
        w_active_nxt = r_active;
      end else if (r_active < r_target) begin
        w_active_nxt = r_active + PWM_W'(1);
      end else if (r_active > r_target) begin
        w_active_nxt = r_active - PWM_W'(1);
      end else begin
        w_active_nxt = r_active;
      end
    end else begin
      w_active_nxt = r_active;
    end
  end
`else
  logic w_unused_fade;
  assign w_unused_fade = i_step ^ i_fade_imm;

  always_comb begin
    w_active_nxt = r_active;
    if (i_load) begin
      w_active_nxt = r_target;
    end else begin
      w_active_nxt = r_active;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= {PWM_W{1'b0}};
    end else begin
      r_active <= w_active_nxt;
    end
  end

  // Counter never reaches MAX, so duty MAX is always on and duty 0 always off.
  assign w_on = (i_cnt < r_active);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led <= P_AL;
    end else if (!i_run) begin
      r_led <= P_AL ^ i_pol;
    end else begin
      r_led <= w_on ^ P_AL ^ i_pol;
    end
  end

  assign o_target = r_target;
  assign o_led    = r_led;

endmodule

// File: rtl/basic_func_pwm_array.sv
// N-channel PWM LED driver top: Avalon-MM registers, Avalon-ST duty stream, shared prescaler
// and period counter. Define PWM_FADE_EN to build the per-boundary fade stepper.
module basic_func_pwm_array
  import basic_func_pwm_pkg::*;
#(
  parameter  int NUM_CH     = 3,
  parameter  int PWM_W      = 8,
  parameter  int PRESC_W    = 16,
  parameter  int ACTIVE_LOW = 1,
  localparam int ADDR_W     = $clog2(NUM_CH + 2)
) (
  input  logic                    csi_MCLK_clk,
  input  logic                    rsi_MRST_reset_n,
  input  logic [ADDR_W-1:0]       avs_LEDD_address,
  input  logic [31:0]             avs_LEDD_writedata,
  output logic [31:0]             avs_LEDD_readdata,
  input  logic [3:0]              avs_LEDD_byteenable,
  input  logic                    avs_LEDD_write,
  input  logic                    avs_LEDD_read,
  input  logic [NUM_CH*PWM_W-1:0] asi_LEDS_data,
  input  logic                    asi_LEDS_valid,
  output logic                    asi_LEDS_ready,
  output logic [NUM_CH-1:0]       coe_LED
);

  localparam logic [PWM_W-1:0]  CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(REG_CTRL);
  localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(REG_PRESC);

  logic               r_run;
  logic               r_pol;
  logic               r_st_en;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [PWM_W-1:0]   r_cnt;
  logic [31:0]        w_mask;
  logic               w_wr_ctrl;
  logic               w_wr_presc;
  logic               w_st_acc;
  logic               w_tick;
  logic               w_boundary;
  logic               w_run_start;
  logic               w_load;
  logic               w_fade_step;
  logic               w_fade_imm;
  logic [31:0]        w_ctrl_rd;
  logic [31:0]        w_presc_rd;
  logic [31:0]        w_duty_rd;
  logic [PWM_W-1:0]   w_target [NUM_CH];
  logic               w_unused;

  assign w_mask      = be_mask(avs_LEDD_byteenable);
  assign w_wr_ctrl   = avs_LEDD_write & (avs_LEDD_address == A_CTRL);
  assign w_wr_presc  = avs_LEDD_write & (avs_LEDD_address == A_PRESC);
  assign w_st_acc    = asi_LEDS_valid & r_st_en;
  assign w_tick      = r_run & (r_presc_cnt == r_presc);
  assign w_boundary  = w_tick & (r_cnt == CNT_LAST);
  // Restarting from stop loads the shadow on the same edge the counter leaves its held zero.
  assign w_run_start = w_wr_ctrl & w_mask[CTRL_RUN_BIT] & avs_LEDD_writedata[CTRL_RUN_BIT] & ~r_run;
  assign w_load      = w_boundary | w_run_start;

  assign asi_LEDS_ready = r_st_en;
  assign w_unused       = &{1'b0, avs_LEDD_read, avs_LEDD_writedata, w_mask};

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_run   <= 1'b1;
      r_pol   <= 1'b0;
      r_st_en <= 1'b0;
      r_presc <= {PRESC_W{1'b0}};
    end else begin
      if (w_wr_ctrl) begin
        r_run   <= (r_run & ~w_mask[CTRL_RUN_BIT]) |
                   (avs_LEDD_writedata[CTRL_RUN_BIT] & w_mask[CTRL_RUN_BIT]);
        r_pol   <= (r_pol & ~w_mask[CTRL_POL_BIT]) |
                   (avs_LEDD_writedata[CTRL_POL_BIT] & w_mask[CTRL_POL_BIT]);
        r_st_en <= (r_st_en & ~w_mask[CTRL_STEN_BIT]) |
                   (avs_LEDD_writedata[CTRL_STEN_BIT] & w_mask[CTRL_STEN_BIT]);
      end
      if (w_wr_presc) begin
        r_presc <= (r_presc & ~w_mask[PRESC_LSB +: PRESC_W]) |
                   (avs_LEDD_writedata[PRESC_LSB +: PRESC_W] & w_mask[PRESC_LSB +: PRESC_W]);
      end
    end
  end

  // A PRESC write restarts the prescale count so a shrinking divider takes effect at once.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_presc_cnt <= {PRESC_W{1'b0}};
    end else if (w_wr_presc || !r_run || w_tick) begin
      r_presc_cnt <= {PRESC_W{1'b0}};
    end else begin
      r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
    end
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_cnt <= {PWM_W{1'b0}};
    end else if (!r_run || w_boundary) begin
      r_cnt <= {PWM_W{1'b0}};
    end else if (w_tick) begin
      r_cnt <= r_cnt + PWM_W'(1);
    end
  end

`ifdef PWM_FADE_EN
  logic [FADE_DIV_W-1:0] r_fade_div;
  logic [FADE_DIV_W-1:0] r_fade_cnt;

  assign w_fade_imm  = (r_fade_div == {FADE_DIV_W{1'b0}});
  assign w_fade_step = (r_fade_cnt >= (r_fade_div - FADE_DIV_W'(1)));

  // Counts load events; every fade_div-th one lets the channels step one code.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_fade_div <= {FADE_DIV_W{1'b0}};
      r_fade_cnt <= {FADE_DIV_W{1'b0}};
    end else if (w_wr_presc) begin
      r_fade_div <= (r_fade_div & ~w_mask[FADE_LSB +: FADE_DIV_W]) |
                    (avs_LEDD_writedata[FADE_LSB +: FADE_DIV_W] & w_mask[FADE_LSB +: FADE_DIV_W]);
      r_fade_cnt <= {FADE_DIV_W{1'b0}};
    end else if (w_load && !w_fade_imm) begin
      r_fade_cnt <= w_fade_step ? {FADE_DIV_W{1'b0}} : r_fade_cnt + FADE_DIV_W'(1);
    end
  end
`else
  assign w_fade_imm  = 1'b1;
  assign w_fade_step = 1'b0;
`endif

  always_comb begin
    w_ctrl_rd                = 32'd0;
    w_ctrl_rd[CTRL_RUN_BIT]  = r_run;
    w_ctrl_rd[CTRL_POL_BIT]  = r_pol;
    w_ctrl_rd[CTRL_STEN_BIT] = r_st_en;
    w_presc_rd                          = 32'd0;
    w_presc_rd[PRESC_LSB +: PRESC_W]    = r_presc;
`ifdef PWM_FADE_EN
    w_presc_rd[FADE_LSB +: FADE_DIV_W]  = r_fade_div;
`else
    w_presc_rd[FADE_LSB +: FADE_DIV_W]  = {FADE_DIV_W{1'b0}};
`endif
    w_duty_rd = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_duty_rd = w_duty_rd | ((avs_LEDD_address == ADDR_W'(REG_DUTY0 + i)) ?
                               {{(32-PWM_W){1'b0}}, w_target[i]} : 32'd0);
    end
  end

  always_comb begin
    avs_LEDD_readdata = 32'd0;
    case (avs_LEDD_address)
      A_CTRL:  avs_LEDD_readdata = w_ctrl_rd;
      A_PRESC: avs_LEDD_readdata = w_presc_rd;
      default: avs_LEDD_readdata = w_duty_rd;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic             w_duty_we;
    logic [PWM_W-1:0] w_duty_wdata;

    assign w_duty_we    = w_st_acc |
                          (avs_LEDD_write & ~r_st_en & (avs_LEDD_address == ADDR_W'(REG_DUTY0 + gi)));
    assign w_duty_wdata = w_st_acc ? asi_LEDS_data[gi*PWM_W +: PWM_W] :
                          ((w_target[gi] & ~w_mask[PWM_W-1:0]) |
                           (avs_LEDD_writedata[PWM_W-1:0] & w_mask[PWM_W-1:0]));

    pwm_led_chan #(
      .PWM_W      (PWM_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .i_clk       (csi_MCLK_clk),
      .i_rst_n     (rsi_MRST_reset_n),
      .i_run       (r_run),
      .i_pol       (r_pol),
      .i_load      (w_load),
      .i_step      (w_fade_step),
      .i_fade_imm  (w_fade_imm),
      .i_cnt       (r_cnt),
      .i_tgt_we    (w_duty_we),
      .i_tgt_wdata (w_duty_wdata),
      .o_target    (w_target[gi]),
      .o_led       (coe_LED[gi])
    );
  end

endmodule

// File: tb/tb_basic_func_pwm_array.sv
// Directed, table-driven bench for basic_func_pwm_array (3 channels, 8-bit, active-low pins).
module tb_basic_func_pwm_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [3:0]  be = 4'd0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [23:0] st_data = 24'd0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [2:0]  led;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  basic_func_pwm_array #(.NUM_CH(3), .PWM_W(8), .PRESC_W(16), .ACTIVE_LOW(1)) dut (
    .csi_MCLK_clk        (clk),
    .rsi_MRST_reset_n    (rst_n),
    .avs_LEDD_address    (addr),
    .avs_LEDD_writedata  (wdata),
    .avs_LEDD_readdata   (rdata),
    .avs_LEDD_byteenable (be),
    .avs_LEDD_write      (wr),
    .avs_LEDD_read       (rd),
    .asi_LEDS_data       (st_data),
    .asi_LEDS_valid      (st_valid),
    .asi_LEDS_ready      (st_ready),
    .coe_LED             (led)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mm_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    @(posedge clk); #1;
    addr = a; wdata = d; be = b; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic mm_read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    addr = a; rd = 1'b1;
    #1;
    check(name, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_low(input int n, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!led[0]) c0++;
      if (!led[1]) c1++;
      if (!led[2]) c2++;
    end
  endtask

  // Returns on the negedge where ch0 first shows its on-state, i.e. counter value 0.
  task automatic sync_period(output logic ok);
    logic prev;
    ok = 1'b0;
    @(negedge clk);
    prev = led[0];
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (prev && !led[0]) ok = 1'b1;
      else prev = led[0];
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0, c1, c2;
    logic ok;

    vecs[0] = '{3'd1, 32'hABCD_0012, 4'b0001, 32'h0000_0012, "presc_lane0"};
    vecs[1] = '{3'd1, 32'hFFFF_34FF, 4'b0010, 32'h0000_3412, "presc_lane1"};
    vecs[2] = '{3'd1, 32'h0000_0000, 4'b1111, 32'h0000_0000, "presc_clear"};
    vecs[3] = '{3'd2, 32'h1234_5640, 4'b0001, 32'h0000_0040, "duty0_lane0"};
    vecs[4] = '{3'd3, 32'h0000_C8AA, 4'b0010, 32'h0000_0000, "duty1_lane1_only"};
    vecs[5] = '{3'd4, 32'hFFFF_FFFF, 4'b1111, 32'h0000_00FF, "duty2_full"};
    vecs[6] = '{3'd5, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, "unmapped5"};
    vecs[7] = '{3'd7, 32'h1234_5678, 4'b1111, 32'h0000_0000, "unmapped7"};
    vecs[8] = '{3'd0, 32'h7FFF_FFFC, 4'b0111, 32'h0000_0000, "ctrl_stop"};
    vecs[9] = '{3'd0, 32'h0000_0001, 4'b1111, 32'h0000_0001, "ctrl_run"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_led", {29'd0, led}, 32'h7);
    check("reset_ready", {31'd0, st_ready}, 32'h0);
    rst_n = 1'b1;
    mm_read_check("reset_ctrl", 3'd0, 32'h0000_0001);
    mm_read_check("reset_presc", 3'd1, 32'h0);
    mm_read_check("reset_duty0", 3'd2, 32'h0);
    mm_read_check("reset_duty1", 3'd3, 32'h0);
    mm_read_check("reset_duty2", 3'd4, 32'h0);

    // Register write/readback table
    for (int i = 0; i < 10; i++) begin
      mm_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      mm_read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Duty 64 / 0 / 255 over one 255-clock period
    wait_clks(300);
    count_low(255, c0, c1, c2);
    check("pwm_duty64", c0, 32'd64);
    check("pwm_duty0", c1, 32'd0);
    check("pwm_duty255", c2, 32'd255);

    // Mid-period write: current period keeps 100, next period exactly 200
    mm_write(3'd3, 32'd100, 4'b1111);
    wait_clks(300);
    sync_period(ok);
    check("sync_ch0", {31'd0, ok}, 32'd1);
    c1 = 0;
    for (int i = 0; i < 255; i++) begin
      if (i > 0) @(negedge clk);
      if (!led[1]) c1++;
      if (i == 10) begin
        addr = 3'd3; wdata = 32'd200; be = 4'b1111; wr = 1'b1;
      end else begin
        wr = 1'b0;
      end
    end
    check("shadow_cur_period", c1, 32'd100);
    count_low(255, c0, c1, c2);
    check("shadow_next_period", c1, 32'd200);

    // Prescaler 1: tick every 2 clocks
    mm_write(3'd1, 32'd1, 4'b1111);
    wait_clks(600);
    count_low(510, c0, c1, c2);
    check("presc1_ch0", c0, 32'd128);
    check("presc1_ch1", c1, 32'd400);
    mm_write(3'd1, 32'd0, 4'b1111);

    // Stream path
    mm_write(3'd0, 32'h8000_0001, 4'b1111);
    check("st_ready_on", {31'd0, st_ready}, 32'd1);
    @(posedge clk); #1;
    st_data = 24'h10_20_30; st_valid = 1'b1;
    addr = 3'd2; wdata = 32'h55; be = 4'b1111; wr = 1'b1;
    @(posedge clk); #1;
    st_valid = 1'b0; wr = 1'b0;
    mm_read_check("st_duty0", 3'd2, 32'h30);
    mm_read_check("st_duty1", 3'd3, 32'h20);
    mm_read_check("st_duty2", 3'd4, 32'h10);
    mm_write(3'd3, 32'h77, 4'b1111);
    mm_read_check("st_mm_dropped", 3'd3, 32'h20);
    mm_write(3'd0, 32'h0000_0001, 4'b1111);
    check("st_ready_off", {31'd0, st_ready}, 32'd0);
    @(posedge clk); #1;
    st_data = 24'hAA_BB_CC; st_valid = 1'b1;
    @(posedge clk); #1;
    st_valid = 1'b0;
    mm_read_check("st_ignored", 3'd2, 32'h30);

    // Polarity via lane-0-only CTRL write
    mm_write(3'd2, 32'd0, 4'b1111);
    mm_write(3'd3, 32'd255, 4'b1111);
    mm_write(3'd4, 32'd0, 4'b1111);
    wait_clks(300);
    check("pol_before", {29'd0, led}, 32'h5);
    mm_write(3'd0, 32'hFFFF_FFFF, 4'b0001);
    check("pol_same_clock", {29'd0, led}, 32'h5);
    mm_read_check("pol_ctrl", 3'd0, 32'h0000_0003);
    wait_clks(1);
    check("pol_inverted", {29'd0, led}, 32'h2);

    // Stop forces off next clock; restart resumes immediately
    mm_write(3'd0, 32'h0, 4'b1111);
    check("stop_same_clock", {29'd0, led}, 32'h2);
    wait_clks(1);
    check("stop_off", {29'd0, led}, 32'h7);
    wait_clks(20);
    check("stop_held", {29'd0, led}, 32'h7);
    mm_write(3'd0, 32'h1, 4'b1111);
    check("restart_same_clock", {29'd0, led}, 32'h7);
    wait_clks(1);
    check("restart_on", {29'd0, led}, 32'h5);

`ifdef PWM_FADE_EN
    mm_write(3'd1, 32'h0002_0000, 4'b1111);
    mm_read_check("fade_div_rd", 3'd1, 32'h0002_0000);
    mm_write(3'd2, 32'd4, 4'b1111);
    count_low(255, c0, c1, c2);
    check("fade_first_period", {31'd0, (c0 <= 1)}, 32'd1);
    wait_clks(12 * 255);
    count_low(255, c0, c1, c2);
    check("fade_up_to4", c0, 32'd4);
    mm_write(3'd2, 32'd2, 4'b1111);
    wait_clks(12 * 255);
    count_low(255, c0, c1, c2);
    check("fade_down_to2", c0, 32'd2);
    mm_write(3'd1, 32'h0, 4'b1111);
`endif

    // Asynchronous reset while a pin is driven on
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", {29'd0, led}, 32'h7);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mm_read_check("post_reset_ctrl", 3'd0, 32'h0000_0001);
    mm_read_check("post_reset_duty1", 3'd3, 32'h0);
    check("post_reset_ready", {31'd0, st_ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
